mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control FSM for the MIPS core. Sequences the shared datapath (single memory, one ALU, IR, A/B/ALUOut registers) through fetch, decode, execute, memory and write-back steps, one state per clock. Replaces the single-cycle decoder when the core moves to a multicycle datapath. Memory states stall on a ready handshake.

## Interface
- `STATE_W`, default 4: state register width; must hold all 12 states.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  6  IR[31:26], valid from DECODE onward.
- `zero`  in  1  ALU zero flag, sampled in BEQ state.
- `mem_ready`  in  1  memory completed access this cycle.
- `pcen`  out  1  PC load: `pcwrite | (branch & zero)`.
- `iord`  out  1  memory address select: 0=PC, 1=ALUOut.
- `memwrite`  out  1  memory write strobe.
- `irwrite`  out  1  IR load.
- `regdst`  out  1  write register select: 1=rd, 0=rt.
- `memtoreg`  out  1  write-back select: 1=data register, 0=ALUOut.
- `regwrite`  out  1  register file write.
- `alusrca`  out  1  ALU A: 0=PC, 1=A register.
- `alusrcb`  out  2  ALU B: 00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- `pcsrc`  out  2  PC next: 00=ALU result, 01=ALUOut, 10=jump target.
- `aluop`  out  2  to ALU decoder: 00=add, 01=sub, 10=funct.
- `instr_done`  out  1  one-cycle pulse in an instruction's last state.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, BEQ, ADDIEXEC, ADDIWB, JUMP.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite=pcwrite=mem_ready. Stays until mem_ready=1, then DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next on op: 100011/101011→MEMADR, 000000→RTEXEC, 000100→BEQ, 001000→ADDIEXEC, 000010→JUMP. Any other op → FETCH, instr_done=1; no architectural write.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. op=100011→MEMRD, else MEMWR.
- MEMRD: iord=1. Holds until mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1 → FETCH.
- MEMWR: iord=1, memwrite=1 held every cycle until mem_ready; instr_done=mem_ready; then FETCH.
- RTEXEC: alusrca=1, alusrcb=00, aluop=10 → RTWB. RTWB: regdst=1, memtoreg=0, regwrite=1, instr_done=1 → FETCH.
- BEQ: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, instr_done=1 → FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, aluop=00 → ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1 → FETCH.
- JUMP: pcsrc=10, pcwrite=1, instr_done=1 → FETCH.
- Unlisted outputs in each state are 0.

## Timing
- Outputs are combinational from registered state (plus `mem_ready`/`zero` where stated); no output registers.
- Reset: rst_n low forces state=FETCH asynchronously; all strobes (pcen, irwrite, memwrite, regwrite, instr_done) gated to 0 while rst_n=0; selects show FETCH values (alusrcb=01, rest 0). First fetch occurs on the first clock edge with rst_n high and mem_ready=1.
- Reset mid-instruction: abandon it; no write completes after rst_n falls.
- Cycles with mem_ready tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each wait cycle adds one in FETCH/MEMRD/MEMWR.
- `op` changes only on irwrite; controller never samples op in FETCH.

## Structure
- Package `mips_ctrl_pkg`: state enum, opcode constants (RTYPE, LW, SW, BEQ, ADDI, J), ALUOp, ALUSrcB and PCSrc encodings; shared with the ALU decoder.
- Sub-module `mc_ctrl_outdec`: pure state→control-word decoder; top holds state register, next-state logic and mem_ready/zero gating.

## Test plan
- Reset held then released, mem_ready=1, op=100011 → states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; instr_done in cycle 5.
- op=101011, mem_ready low 3 cycles in MEMWR → memwrite=1 for 4 cycles, instr_done once, back to FETCH.
- op=000100 with zero=1 → pcen=1, pcsrc=01 in BEQ; repeat zero=0 → pcen=0.
- op=000000 then 001000 back-to-back → 4+4 cycles, regdst=1 in RTWB, 0 in ADDIWB, aluop 10 vs 00.
- op=111111 → FETCH,DECODE,FETCH; regwrite/memwrite never asserted.
- rst_n dropped in MEMWB → regwrite falls immediately, state FETCH, all strobes 0 until release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// ALU/PC select codes and the decoded control word.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_RTEXEC, S_RTWB, S_BEQ, S_ADDIEXEC, S_ADDIWB, S_JUMP
   } state_e;

   localparam int unsigned STATE_BITS = $bits(state_e);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} aluop_e;
   typedef enum logic [1:0] {SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMMSH = 2'b11} alusrcb_e;
   typedef enum logic [1:0] {PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10} pcsrc_e;

   // wait_ready marks states whose pcwrite/irwrite/done only count once memory answers.
   typedef struct packed {
      logic     iord;
      logic     memwrite;
      logic     irwrite;
      logic     pcwrite;
      logic     branch;
      logic     regdst;
      logic     memtoreg;
      logic     regwrite;
      logic     alusrca;
      alusrcb_e alusrcb;
      pcsrc_e   pcsrc;
      aluop_e   aluop;
      logic     done;
      logic     wait_ready;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [5:0] opc);
      return opc inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
   endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Pure state -> control-word decoder for the multicycle controller; no
// handshake or reset qualification happens here.
module mc_ctrl_outdec
   import mips_ctrl_pkg::*;
(
   input  state_e state_i,
   output ctrl_t  ctrl_o
);

   always_comb begin
      // NOTE: full default before the case so every field is driven on every path (no latches).
      ctrl_o         = '0;
      ctrl_o.alusrcb = SRCB_B;
      ctrl_o.pcsrc   = PCSRC_ALU;
      ctrl_o.aluop   = ALUOP_ADD;
      case (state_i)
         S_FETCH: begin
            ctrl_o.alusrcb    = SRCB_FOUR;
            ctrl_o.irwrite    = 1'b1;
            ctrl_o.pcwrite    = 1'b1;
            ctrl_o.wait_ready = 1'b1;
         end
         S_DECODE:   ctrl_o.alusrcb = SRCB_IMMSH;
         S_MEMADR: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl_o.iord       = 1'b1;
            ctrl_o.wait_ready = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.memtoreg = 1'b1;
            ctrl_o.regwrite = 1'b1;
            ctrl_o.done     = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.iord       = 1'b1;
            ctrl_o.memwrite   = 1'b1;
            ctrl_o.done       = 1'b1;
            ctrl_o.wait_ready = 1'b1;
         end
         S_RTEXEC: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.aluop   = ALUOP_FUNCT;
         end
         S_RTWB: begin
            ctrl_o.regdst   = 1'b1;
            ctrl_o.regwrite = 1'b1;
            ctrl_o.done     = 1'b1;
         end
         S_BEQ: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.aluop   = ALUOP_SUB;
            ctrl_o.pcsrc   = PCSRC_ALUOUT;
            ctrl_o.branch  = 1'b1;
            ctrl_o.done    = 1'b1;
         end
         S_ADDIEXEC: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = SRCB_IMM;
         end
         S_ADDIWB: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.done     = 1'b1;
         end
         S_JUMP: begin
            ctrl_o.pcsrc   = PCSRC_JUMP;
            ctrl_o.pcwrite = 1'b1;
            ctrl_o.done    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: state register, next-state logic, and the
// mem_ready / zero / reset qualification of the decoded control strobes.
module mc_controller
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned STATE_W = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcen,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [1:0] aluop,
   output logic       instr_done
);

   logic [STATE_W-1:0] state_q;
   state_e             state;
   state_e             state_d;
   ctrl_t              ctrl;
   logic               rdy_ok;
   logic               illegal_dec;

   assign state = state_e'(state_q[STATE_BITS-1:0]);

   always_comb begin
      state_d = S_FETCH;
      case (state)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTEXEC;
               OP_BEQ:       state_d = S_BEQ;
               OP_ADDI:      state_d = S_ADDIEXEC;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_RTEXEC:   state_d = S_RTWB;
         S_ADDIEXEC: state_d = S_ADDIWB;
         default:    state_d = S_FETCH;
      endcase
   end

   // NOTE: state is sequential, so only non-blocking assignments here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= STATE_W'(S_FETCH);
      else        state_q <= STATE_W'(state_d);
   end

   mc_ctrl_outdec u_outdec (
      .state_i (state),
      .ctrl_o  (ctrl)
   );

   assign rdy_ok      = ~ctrl.wait_ready | mem_ready;
   assign illegal_dec = (state == S_DECODE) & ~is_legal_op(op);

   // Strobes are also gated by rst_n so a write in flight dies the instant reset falls.
   assign pcen       = rst_n & ((ctrl.pcwrite & rdy_ok) | (ctrl.branch & zero));
   assign irwrite    = rst_n & ctrl.irwrite & rdy_ok;
   assign memwrite   = rst_n & ctrl.memwrite;
   assign regwrite   = rst_n & ctrl.regwrite;
   assign instr_done = rst_n & ((ctrl.done & rdy_ok) | illegal_dec);

   assign iord     = ctrl.iord;
   assign regdst   = ctrl.regdst;
   assign memtoreg = ctrl.memtoreg;
   assign alusrca  = ctrl.alusrca;
   assign alusrcb  = ctrl.alusrcb;
   assign pcsrc    = ctrl.pcsrc;
   assign aluop    = ctrl.aluop;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: instructions are expanded into
// per-cycle {inputs, expected control word} records and compared each cycle.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, instr_done;
   logic [1:0] alusrcb, pcsrc, aluop;

   mc_controller #(.STATE_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pcen       (pcen),
      .iord       (iord),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .aluop      (aluop),
      .instr_done (instr_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
      logic [1:0] alusrcb, pcsrc, aluop;
      logic       instr_done;
   } ctl_t;

   typedef struct {
      logic       mr;
      logic       z;
      logic [5:0] op;
      ctl_t       exp;
      string      tag;
   } vec_t;

   typedef struct {
      logic [5:0] op;
      int         wf;
      int         wm;
      logic       z;
   } instr_t;

   ctl_t       act;
   vec_t       q[$];
   logic [5:0] cur_op;
   int         n_checks = 0;
   int         n_errors = 0;

   assign act = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, aluop, instr_done};

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit legal(input logic [5:0] o);
      return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
   endfunction

   function automatic ctl_t reset_word();
      ctl_t w = '0;
      w.alusrcb = 2'b01;
      return w;
   endfunction

   task automatic check(input string name, input ctl_t a, input ctl_t e);
      n_checks++;
      if (a !== e) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
      end
   endtask

   task automatic push(input logic mr, input logic z, input ctl_t w, input string tag);
      vec_t v;
      v.mr = mr; v.z = z; v.op = cur_op; v.exp = w; v.tag = tag;
      q.push_back(v);
   endtask

   // Expand one instruction into the cycle-by-cycle control words it must produce.
   task automatic gen_instr(input instr_t in);
      ctl_t w;
      for (int i = 0; i < in.wf; i++) push(1'b0, rbit(), reset_word(), "fetch_wait");
      w = reset_word(); w.irwrite = 1'b1; w.pcen = 1'b1;
      push(1'b1, rbit(), w, "fetch");
      cur_op = in.op;
      w = '0; w.alusrcb = 2'b11; w.instr_done = !legal(in.op);
      push(rbit(), rbit(), w, "decode");
      case (in.op)
         6'b100011, 6'b101011: begin
            w = '0; w.alusrca = 1'b1; w.alusrcb = 2'b10;
            push(rbit(), rbit(), w, "memadr");
            if (in.op == 6'b100011) begin
               w = '0; w.iord = 1'b1;
               for (int i = 0; i < in.wm; i++) push(1'b0, rbit(), w, "memrd_wait");
               push(1'b1, rbit(), w, "memrd");
               w = '0; w.memtoreg = 1'b1; w.regwrite = 1'b1; w.instr_done = 1'b1;
               push(rbit(), rbit(), w, "memwb");
            end else begin
               w = '0; w.iord = 1'b1; w.memwrite = 1'b1;
               for (int i = 0; i < in.wm; i++) push(1'b0, rbit(), w, "memwr_wait");
               w.instr_done = 1'b1;
               push(1'b1, rbit(), w, "memwr");
            end
         end
         6'b000000: begin
            w = '0; w.alusrca = 1'b1; w.aluop = 2'b10;
            push(rbit(), rbit(), w, "rtexec");
            w = '0; w.regdst = 1'b1; w.regwrite = 1'b1; w.instr_done = 1'b1;
            push(rbit(), rbit(), w, "rtwb");
         end
         6'b000100: begin
            w = '0; w.alusrca = 1'b1; w.aluop = 2'b01; w.pcsrc = 2'b01;
            w.pcen = in.z; w.instr_done = 1'b1;
            push(rbit(), in.z, w, "beq");
         end
         6'b001000: begin
            w = '0; w.alusrca = 1'b1; w.alusrcb = 2'b10;
            push(rbit(), rbit(), w, "addiexec");
            w = '0; w.regwrite = 1'b1; w.instr_done = 1'b1;
            push(rbit(), rbit(), w, "addiwb");
         end
         6'b000010: begin
            w = '0; w.pcsrc = 2'b10; w.pcen = 1'b1; w.instr_done = 1'b1;
            push(rbit(), rbit(), w, "jump");
         end
         default: ;
      endcase
   endtask

   // Called just after a rising edge: drive, let outputs settle, compare, advance.
   task automatic apply(input vec_t v);
      mem_ready = v.mr;
      zero      = v.z;
      op        = v.op;
      #1;
      check(v.tag, act, v.exp);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      while (q.size() > 0) apply(q.pop_front());
   endtask

   instr_t dir [10];
   instr_t ri;
   vec_t   v;

   initial begin
      dir[0] = '{6'b100011, 0, 0, 1'b0};  // lw, no waits
      dir[1] = '{6'b101011, 0, 3, 1'b0};  // sw, 3 memory wait cycles
      dir[2] = '{6'b000100, 0, 0, 1'b1};  // beq taken
      dir[3] = '{6'b000100, 0, 0, 1'b0};  // beq not taken
      dir[4] = '{6'b000000, 0, 0, 1'b0};  // R-type
      dir[5] = '{6'b001000, 0, 0, 1'b0};  // addi right after
      dir[6] = '{6'b111111, 0, 0, 1'b0};  // illegal
      dir[7] = '{6'b000010, 0, 0, 1'b0};  // j
      dir[8] = '{6'b100011, 2, 2, 1'b0};  // lw with fetch and read waits
      dir[9] = '{6'b011111, 1, 0, 1'b0};  // another illegal

      rst_n     = 1'b0;
      mem_ready = 1'b1;
      zero      = 1'b1;
      op        = 6'b100011;
      cur_op    = 6'b100011;
      #2;
      check("reset_async", act, reset_word());
      repeat (2) begin
         @(posedge clk);
         #1;
         check("reset_held", act, reset_word());
      end
      rst_n = 1'b1;

      foreach (dir[i]) gen_instr(dir[i]);
      drain();

      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 7))
            0: ri.op = 6'b100011;
            1: ri.op = 6'b101011;
            2: ri.op = 6'b000000;
            3: ri.op = 6'b000100;
            4: ri.op = 6'b001000;
            5: ri.op = 6'b000010;
            6: ri.op = 6'b111111;
            default: ri.op = 6'($urandom);
         endcase
         ri.wf = $urandom_range(0, 2);
         ri.wm = $urandom_range(0, 2);
         ri.z  = rbit();
         gen_instr(ri);
      end
      drain();

      // Reset dropped while lw sits in its write-back cycle.
      gen_instr('{6'b100011, 0, 0, 1'b0});
      for (int i = 0; i < 4; i++) apply(q.pop_front());
      v = q.pop_front();
      mem_ready = v.mr; zero = v.z; op = v.op;
      #1;
      check("memwb_before_reset", act, v.exp);
      #1;
      rst_n = 1'b0;
      mem_ready = 1'b1;
      #1;
      check("reset_in_memwb", act, reset_word());
      repeat (2) begin
         @(posedge clk);
         #1;
         check("reset_held_mid", act, reset_word());
      end
      rst_n = 1'b1;
      gen_instr('{6'b000010, 0, 0, 1'b0});
      gen_instr('{6'b001000, 1, 0, 1'b0});
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
